// File: rtl/prog_mem_ldr.sv
// Program memory with a byte-stream loader. Optional even parity per word when PMEM_PARITY_EN is defined.
// Latency: fetch is registered (1 cycle). A load takes NB+1 cycles per instruction plus one DONE cycle.
// Backpressure: ld_ready is high only in COLLECT with e=1. Dropping e stalls both fetch and loading.
module prog_mem_ldr #(
  parameter int IW = 12,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          e,
  input  logic [AW-1:0] addr,
  output logic [IW-1:0] I,
  output logic          i_valid,
  input  logic          ld_start,
  input  logic [AW-1:0] ld_base,
  input  logic [AW:0]   ld_count,
  input  logic [7:0]    ld_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  output logic          ld_busy,
  output logic          ld_done
`ifdef PMEM_PARITY_EN
  ,
  output logic          par_err
`endif
);

  localparam int NB    = (IW + 7) / 8;
  localparam int DEPTH = 2 ** AW;
`ifdef PMEM_PARITY_EN
  localparam int MW = IW + 1;
`else
  localparam int MW = IW;
`endif

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] la_q, la_d;      // next load address, wraps naturally
  logic [AW:0]   rem_q, rem_d;    // instructions still to write
  logic [2:0]    idx_q, idx_d;    // byte index within the current word
  logic [IW-1:0] asm_q, asm_d;    // word being assembled; bits above IW are never stored
  logic [IW-1:0] i_q, i_d;
  logic          iv_q, iv_d;
  logic          wr_en;
  logic [MW-1:0] wr_word;
  logic [MW-1:0] rd_word;

  logic [MW-1:0] mem [DEPTH];

`ifdef PMEM_PARITY_EN
  logic par_q, par_d;
  assign wr_word = {^asm_q, asm_q};
  assign par_err = par_q;
`else
  assign wr_word = asm_q;
`endif

  // Fetch path: the read sees the pre-write contents on a same-address collision.
  assign rd_word = mem[addr];
  always_comb begin
    i_d  = '0;
    iv_d = 1'b0;
`ifdef PMEM_PARITY_EN
    par_d = 1'b0;
`endif
    if (e) begin
      i_d  = rd_word[IW-1:0];
      iv_d = 1'b1;
`ifdef PMEM_PARITY_EN
      par_d = ^rd_word;
`endif
    end
  end

  // Loader FSM: next state, datapath updates and handshake outputs.
  always_comb begin
    state_d  = state_q;
    la_d     = la_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    asm_d    = asm_q;
    wr_en    = 1'b0;
    ld_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ld_start && e) begin
          la_d    = ld_base;
          rem_d   = ld_count;
          idx_d   = '0;
          asm_d   = '0;
          state_d = (ld_count == '0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        ld_ready = e;
        if (ld_valid && e) begin
          // Little-endian placement; bit b belongs to byte b/8.
          for (int b = 0; b < IW; b++) begin
            if (idx_q == 3'(b / 8)) asm_d[b] = ld_data[b % 8];
          end
          if (idx_q == 3'(NB - 1)) begin
            idx_d   = '0;
            state_d = S_WRITE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_WRITE: begin
        if (e) begin
          wr_en   = 1'b1;
          la_d    = la_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == (AW+1)'(1)) ? S_DONE : S_COLLECT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ld_busy = (state_q != S_IDLE);
  assign ld_done = (state_q == S_DONE);
  assign I       = i_q;
  assign i_valid = iv_q;

  // State and output registers; a reset mid-load simply discards the partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      la_q    <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      i_q     <= '0;
      iv_q    <= 1'b0;
`ifdef PMEM_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      la_q    <= la_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      i_q     <= i_d;
      iv_q    <= iv_d;
`ifdef PMEM_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Storage array: not reset, so written words survive a load abort.
  always_ff @(posedge clk) begin
    if (wr_en) mem[la_q] <= wr_word;
  end

endmodule
